// File: rtl/hpb_wr_master_pkg.sv
// Shared types and constants for the host-side parameter RAM write initiator.
package hpb_wr_master_pkg;

    localparam int unsigned HPB_ADDR_W = 14;

    typedef enum logic [1:0] {
        HPB_IDLE,
        HPB_REQ,
        HPB_RELEASE
    } hpb_state_t;

    // Ceiling log2, never below 1 so a pointer always has at least one bit.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hpb_fifo.sv
// Synchronous FIFO buffering host writes; count-based full/empty, no bypass.
module hpb_fifo
    import hpb_wr_master_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = log2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hpb_wr_master.sv
// Buffers host config writes and issues them one at a time on the hpb_wr_* request port.
module hpb_wr_master
    import hpb_wr_master_pkg::*;
#(
    parameter int unsigned HPB_RAM_WIDTH  = 64,
    parameter int unsigned HPB_FIFO_DEPTH = 4,
    parameter int unsigned HPB_STALL_MAX  = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic [HPB_ADDR_W-1:0]      host_addr,
    input  logic [HPB_RAM_WIDTH-1:0]   host_data,
    input  logic [HPB_RAM_WIDTH/8-1:0] host_be,
    output logic                       hpb_wr_req,
    output logic [HPB_ADDR_W-1:0]      hpb_wr_addr,
    output logic [HPB_RAM_WIDTH-1:0]   hpb_wr_data,
    output logic [HPB_RAM_WIDTH/8-1:0] hpb_wr_en,
    input  logic                       rcb_wr_done,
    input  logic                       stall_clr,
    output logic                       hpb_busy,
    output logic                       hpb_stall,
    output logic [15:0]                hpb_wr_cnt
);

    localparam int unsigned BE_W    = HPB_RAM_WIDTH / 8;
    localparam int unsigned ENTRY_W = HPB_ADDR_W + HPB_RAM_WIDTH + BE_W;
    localparam int unsigned STALL_W = $clog2(HPB_STALL_MAX + 1);

    hpb_state_t          state;
    logic [STALL_W-1:0]  stall_cnt;
    logic [ENTRY_W-1:0]  head;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                stall_set;

    assign host_ready = !full;
    assign push       = host_valid && !full;
    assign pop        = !empty && (state == HPB_IDLE || state == HPB_RELEASE);
    assign hpb_busy   = (state != HPB_IDLE) || !empty;
    // Fires only on the step into HPB_STALL_MAX, so a saturated counter never re-sets the flag.
    assign stall_set  = (state == HPB_REQ) && !rcb_wr_done &&
                        (stall_cnt == STALL_W'(HPB_STALL_MAX - 1));

    hpb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (HPB_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     ({host_addr, host_data, host_be}),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HPB_IDLE;
            hpb_wr_req  <= 1'b0;
            hpb_wr_addr <= '0;
            hpb_wr_data <= '0;
            hpb_wr_en   <= '0;
            stall_cnt   <= '0;
            hpb_stall   <= 1'b0;
            hpb_wr_cnt  <= '0;
        end else begin
            if (stall_clr)      hpb_stall <= 1'b0;
            else if (stall_set) hpb_stall <= 1'b1;

            case (state)
                HPB_IDLE, HPB_RELEASE: begin
                    if (!empty) begin
                        {hpb_wr_addr, hpb_wr_data, hpb_wr_en} <= head;
                        hpb_wr_req <= 1'b1;
                        state      <= HPB_REQ;
                    end else begin
                        hpb_wr_req <= 1'b0;
                        state      <= HPB_IDLE;
                    end
                end
                HPB_REQ: begin
                    if (rcb_wr_done) begin
                        hpb_wr_req <= 1'b0;
                        hpb_wr_cnt <= hpb_wr_cnt + 16'd1;
                        stall_cnt  <= '0;
                        state      <= HPB_RELEASE;
                    end else if (stall_cnt != STALL_W'(HPB_STALL_MAX)) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                default: begin
                    hpb_wr_req <= 1'b0;
                    state      <= HPB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpb_wr_master.sv
// Directed bench for hpb_wr_master: latency, back-to-back, stall, reset, full FIFO, wrap.
module tb_hpb_wr_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_valid;
    logic        host_ready;
    logic [13:0] host_addr;
    logic [63:0] host_data;
    logic [7:0]  host_be;
    logic        hpb_wr_req;
    logic [13:0] hpb_wr_addr;
    logic [63:0] hpb_wr_data;
    logic [7:0]  hpb_wr_en;
    logic        rcb_wr_done;
    logic        stall_clr;
    logic        hpb_busy;
    logic        hpb_stall;
    logic [15:0] hpb_wr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hpb_wr_master #(
        .HPB_RAM_WIDTH  (64),
        .HPB_FIFO_DEPTH (4),
        .HPB_STALL_MAX  (255)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .host_be     (host_be),
        .hpb_wr_req  (hpb_wr_req),
        .hpb_wr_addr (hpb_wr_addr),
        .hpb_wr_data (hpb_wr_data),
        .hpb_wr_en   (hpb_wr_en),
        .rcb_wr_done (rcb_wr_done),
        .stall_clr   (stall_clr),
        .hpb_busy    (hpb_busy),
        .hpb_stall   (hpb_stall),
        .hpb_wr_cnt  (hpb_wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        host_valid  = 1'b0;
        host_addr   = '0;
        host_data   = '0;
        host_be     = '0;
        rcb_wr_done = 1'b0;
        stall_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [63:0] data_of(input logic [13:0] a);
        return 64'hC0DE_0000_0000_0000 | 64'(a);
    endfunction

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({hpb_wr_req, host_ready, hpb_busy, hpb_stall} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags: got req/ready/busy/stall=%b want 0100",
                     {hpb_wr_req, host_ready, hpb_busy, hpb_stall});
        end
        checks++;
        if (hpb_wr_cnt !== 16'd0 || hpb_wr_addr !== 14'd0 || hpb_wr_data !== 64'd0 ||
            hpb_wr_en !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: got cnt=%h addr=%h data=%h en=%h want all 0",
                     hpb_wr_cnt, hpb_wr_addr, hpb_wr_data, hpb_wr_en);
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        rcb_wr_done = 1'b1;
        host_valid  = 1'b1;
        host_addr   = 14'h0123;
        host_data   = 64'hDEAD_BEEF_0000_0001;
        host_be     = 8'hFF;
        tick();
        host_valid = 1'b0;
        checks++;
        if (hpb_wr_req !== 1'b0 || hpb_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_n1: got req=%b busy=%b want req=0 busy=1", hpb_wr_req, hpb_busy);
        end
        tick();
        checks++;
        if (hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h0123 ||
            hpb_wr_data !== 64'hDEAD_BEEF_0000_0001 || hpb_wr_en !== 8'hFF) begin
            errors++;
            $display("FAIL single_n2: got req=%b addr=%h data=%h en=%h want 1 0123 deadbeef00000001 ff",
                     hpb_wr_req, hpb_wr_addr, hpb_wr_data, hpb_wr_en);
        end
        tick();
        checks++;
        if (hpb_wr_req !== 1'b0 || hpb_wr_cnt !== 16'd1 || hpb_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_release: got req=%b cnt=%0d busy=%b want 0 1 1",
                     hpb_wr_req, hpb_wr_cnt, hpb_busy);
        end
        tick();
        checks++;
        if (hpb_busy !== 1'b0 || hpb_wr_cnt !== 16'd1 || hpb_wr_addr !== 14'h0123) begin
            errors++;
            $display("FAIL single_idle: got busy=%b cnt=%0d addr=%h want 0 1 0123",
                     hpb_busy, hpb_wr_cnt, hpb_wr_addr);
        end
        rcb_wr_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1;
            host_addr  = 14'h100 + 14'(i);
            host_data  = data_of(14'h100 + 14'(i));
            host_be    = 8'(1 << i);
            checks++;
            if (host_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got %b want 1", i, host_ready);
            end
            tick();
        end
        host_valid = 1'b0;
        checks++;
        if (host_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: got ready=%b want 0", host_ready);
        end
        rcb_wr_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h100 + 14'(i) ||
                hpb_wr_data !== data_of(14'h100 + 14'(i)) || hpb_wr_en !== 8'(1 << i)) begin
                errors++;
                $display("FAIL b2b_req_%0d: got req=%b addr=%h en=%h want 1 %h %h",
                         i, hpb_wr_req, hpb_wr_addr, hpb_wr_en, 14'h100 + 14'(i), 8'(1 << i));
            end
            tick();
            checks++;
            if (hpb_wr_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap_%0d: got req=%b want 0", i, hpb_wr_req);
            end
            tick();
        end
        checks++;
        if (hpb_wr_cnt !== 16'd5 || hpb_busy !== 1'b0 || hpb_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got cnt=%0d busy=%b req=%b want 5 0 0",
                     hpb_wr_cnt, hpb_busy, hpb_wr_req);
        end
        rcb_wr_done = 1'b0;
    endtask

    task automatic test_stall();
        apply_reset();
        host_valid = 1'b1;
        host_addr  = 14'h2AAA;
        host_data  = 64'h0123_4567_89AB_CDEF;
        host_be    = 8'h0F;
        tick();
        host_valid = 1'b0;
        tick();
        for (int i = 1; i <= 300; i++) begin
            checks++;
            if (hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h2AAA ||
                hpb_wr_data !== 64'h0123_4567_89AB_CDEF || hpb_wr_en !== 8'h0F) begin
                errors++;
                $display("FAIL stall_hold_%0d: got req=%b addr=%h data=%h en=%h",
                         i, hpb_wr_req, hpb_wr_addr, hpb_wr_data, hpb_wr_en);
            end
            tick();
            if (i == 254 || i == 255 || i == 300) begin
                checks++;
                if (hpb_stall !== (i >= 255)) begin
                    errors++;
                    $display("FAIL stall_flag_%0d: got %b want %b", i, hpb_stall, i >= 255);
                end
            end
        end
        rcb_wr_done = 1'b1;
        tick();
        rcb_wr_done = 1'b0;
        checks++;
        if (hpb_wr_req !== 1'b0 || hpb_wr_cnt !== 16'd1 || hpb_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: got req=%b cnt=%0d stall=%b want 0 1 1",
                     hpb_wr_req, hpb_wr_cnt, hpb_stall);
        end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checks++;
        if (hpb_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_clr: got %b want 0", hpb_stall);
        end
        // Second request: clear lands on the exact edge the flag would set.
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        tick();
        repeat (254) tick();
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checks++;
        if (hpb_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_clr_priority: got %b want 0", hpb_stall);
        end
        repeat (20) tick();
        checks++;
        if (hpb_stall !== 1'b0 || hpb_wr_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_saturated: got stall=%b req=%b want 0 1", hpb_stall, hpb_wr_req);
        end
        rcb_wr_done = 1'b1;
        tick();
        rcb_wr_done = 1'b0;
        tick();
        checks++;
        if (hpb_wr_cnt !== 16'd2 || hpb_busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: got cnt=%0d busy=%b want 2 0", hpb_wr_cnt, hpb_busy);
        end
    endtask

    task automatic test_reset_mid_request();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1;
            host_addr  = 14'h200 + 14'(i);
            host_data  = data_of(14'h200 + 14'(i));
            host_be    = 8'hAA;
            tick();
        end
        host_valid = 1'b0;
        checks++;
        if (hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h200) begin
            errors++;
            $display("FAIL rst_mid_pre: got req=%b addr=%h want 1 0200", hpb_wr_req, hpb_wr_addr);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (hpb_wr_req !== 1'b0 || host_ready !== 1'b1 || hpb_wr_cnt !== 16'd0 ||
            hpb_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got req=%b ready=%b cnt=%0d busy=%b want 0 1 0 0",
                     hpb_wr_req, host_ready, hpb_wr_cnt, hpb_busy);
        end
        #3;
        reset_n     = 1'b1;
        rcb_wr_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (hpb_wr_req !== 1'b0 || hpb_wr_cnt !== 16'd0) begin
                errors++;
                $display("FAIL rst_mid_quiet_%0d: got req=%b cnt=%0d want 0 0",
                         i, hpb_wr_req, hpb_wr_cnt);
            end
        end
        rcb_wr_done = 1'b0;
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1;
            host_addr  = 14'h300 + 14'(i);
            host_data  = data_of(14'h300 + 14'(i));
            host_be    = 8'h33;
            tick();
        end
        host_addr = 14'h305;
        host_data = data_of(14'h305);
        checks++;
        if (host_ready !== 1'b0 || hpb_wr_addr !== 14'h300) begin
            errors++;
            $display("FAIL full_pre: got ready=%b addr=%h want 0 0300", host_ready, hpb_wr_addr);
        end
        rcb_wr_done = 1'b1;
        tick();
        rcb_wr_done = 1'b0;
        checks++;
        if (host_ready !== 1'b0 || hpb_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL full_refused: got ready=%b req=%b want 0 0", host_ready, hpb_wr_req);
        end
        tick();
        checks++;
        if (host_ready !== 1'b1 || hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h301) begin
            errors++;
            $display("FAIL full_reopen: got ready=%b req=%b addr=%h want 1 1 0301",
                     host_ready, hpb_wr_req, hpb_wr_addr);
        end
        tick();
        host_valid = 1'b0;
        checks++;
        if (host_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_accepted: got ready=%b want 0", host_ready);
        end
        rcb_wr_done = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            checks++;
            if (hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h300 + 14'(j) ||
                hpb_wr_data !== data_of(14'h300 + 14'(j))) begin
                errors++;
                $display("FAIL full_drain_%0d: got req=%b addr=%h want 1 %h",
                         j, hpb_wr_req, hpb_wr_addr, 14'h300 + 14'(j));
            end
            tick();
            tick();
        end
        tick();
        checks++;
        if (hpb_wr_cnt !== 16'd6 || hpb_wr_req !== 1'b0 || hpb_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_end: got cnt=%0d req=%b busy=%b want 6 0 0",
                     hpb_wr_cnt, hpb_wr_req, hpb_busy);
        end
        rcb_wr_done = 1'b0;
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        @(negedge clk);
        force dut.hpb_wr_cnt = 16'hFFFF;
        #1;
        release dut.hpb_wr_cnt;
        tick();
        checks++;
        if (hpb_wr_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h want ffff", hpb_wr_cnt);
        end
        rcb_wr_done = 1'b1;
        host_valid  = 1'b1;
        host_addr   = 14'h3FFF;
        host_data   = data_of(14'h3FFF);
        host_be     = 8'h81;
        tick();
        host_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (hpb_wr_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: got %h want 0000", hpb_wr_cnt);
        end
        rcb_wr_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_reset_mid_request();
        test_full_push_pop();
        test_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
